uart_rx_fifo: RTL and testbench

UART receiver for the FPGA CPU's serial port, mirroring the transmitter behind `tx`. It deserialises 8N1 frames from the `rx` pin, oversampled on the system clock, and queues received bytes in a 4-entry FIFO. The CPU drains the FIFO through a valid/ready handshake. The block sits between the board `rx` pin and the CPU's I/O read path.

---
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a valid/ready byte FIFO; define UART_RX_PARITY_EN for 8E1 frames.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       btnc,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif
  state_t state, state_n;
  logic sync1, rxs, good, push, ferr, pop, full, wr;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitn, bitn_n;
  logic [7:0] shreg, shreg_n;
  logic [AW:0] wp, rp;
  logic [7:0] mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic perr, perr_n;
  assign good = rxs & ~perr;
`else
  assign good = rxs;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bitn_n  = bitn;
    shreg_n = shreg;
    push    = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n  = perr;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rxs ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        bitn_n = '0;
        state_n = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        perr_n = 1'b0;
`endif
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        shreg_n = {rxs, shreg[7:1]};
        bitn_n = bitn + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_n = bitn == 3'd7 ? PARITY : DATA;
`else
        state_n = bitn == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == LAST) begin
        cnt_n = '0;
        perr_n = rxs ^ (^shreg);
        state_n = STOP;
      end
`endif
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        push = good;
        ferr = ~good;
        state_n = good ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = rxs ? IDLE : WAIT_HIGH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge btnc) begin
    if (btnc) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
      perr  <= perr_n;
`endif
    end
  end
  assign rx_valid = wp != rp;
  assign rx_data  = mem[rp[AW-1:0]];
  assign pop      = rx_valid & rx_ready;
  assign full     = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign wr       = push & (~full | pop);
  always_ff @(posedge clk or posedge btnc) begin
    if (btnc) begin
      wp        <= '0;
      rp        <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) mem[wp[AW-1:0]] <= shreg;
      wp        <= wp + (AW+1)'(wr);
      rp        <= rp + (AW+1)'(pop);
      frame_err <= ferr;
      overrun   <= push & ~wr;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: frame-level reference model with per-cycle compare plus directed and random frames.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 3 + CPB / 2 + (NB - 1) * CPB;
  logic clk = 1'b0, btnc = 1'b1, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun;
  int cyc = 0, checks = 0, failures = 0, n_fe = 0, n_ov = 0;
  int rdy_mode = 0, pop_at = -1;
  logic [7:0] q[$];
  int ev_kind[int];
  logic [7:0] ev_data[int];
  bit pend = 1'b0;
  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .btnc(btnc), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );
  always #1 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #0.5;
    end
  endtask
  task automatic send(input logic [7:0] d, input bit stop, input int cut);
    logic [NB-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, ^d, d, 1'b0};
`else
    bits = {stop, d, 1'b0};
`endif
    if (cut == NB) begin
      ev_kind[cyc + LAT] = stop ? 1 : 2;
      ev_data[cyc + LAT] = d;
    end
    for (int i = 0; i < cut; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #0.4;
    rx_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : (rdy_mode == 1 || cyc == pop_at);
  end
  always @(negedge clk) begin
    if (btnc) begin
      q.delete();
      pend = 1'b0;
      chk("reset_valid", rx_valid, 0);
      chk("reset_flags", {frame_err, overrun}, 0);
    end else begin
      bit was_full, exp_fe, exp_ov;
      was_full = q.size() == DEPTH;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (pend) void'(q.pop_front());
      if (ev_kind.exists(cyc)) begin
        if (ev_kind[cyc] == 2) exp_fe = 1'b1;
        else if (!was_full || pend) q.push_back(ev_data[cyc]);
        else exp_ov = 1'b1;
        ev_kind.delete(cyc);
      end
      chk("rx_valid", rx_valid, q.size() != 0);
      if (q.size() != 0) chk("rx_data", rx_data, q[0]);
      chk("frame_err", frame_err, exp_fe);
      chk("overrun", overrun, exp_ov);
      n_fe += frame_err;
      n_ov += overrun;
      pend = q.size() != 0 && rx_ready;
    end
  end
  initial begin
    int k, f0, o0;
    tick(3);
    chk("lit_reset_valid", rx_valid, 0);
    chk("lit_reset_data", rx_data, 8'h00);
    chk("lit_reset_flags", {frame_err, overrun}, 0);
    btnc = 1'b0;
    tick(3);
    rdy_mode = 1;
    k = cyc;
    send(8'h55, 1'b1, NB);
    tick(k + LAT - cyc);
    chk("lit_single_valid", rx_valid, 1);
    chk("lit_single_data", rx_data, 8'h55);
    tick(1);
    chk("lit_single_gone", rx_valid, 0);
    rdy_mode = 0;
    tick(2);
    send(8'hA3, 1'b1, NB);
    send(8'h0F, 1'b1, NB);
    tick(4);
    chk("lit_b2b_count", q.size(), 2);
    chk("lit_b2b_first", rx_data, 8'hA3);
    pop_at = cyc + 1;
    tick(2);
    chk("lit_b2b_second", rx_data, 8'h0F);
    pop_at = cyc + 1;
    tick(2);
    chk("lit_b2b_empty", rx_valid, 0);
    f0 = n_fe;
    rx = 1'b0;
    tick(CPB / 2 - 1);
    rx = 1'b1;
    tick(8);
    chk("lit_glitch_valid", rx_valid, 0);
    chk("lit_glitch_fe", n_fe - f0, 0);
    send(8'h3C, 1'b1, NB);
    tick(4);
    chk("lit_after_glitch", rx_data, 8'h3C);
    rdy_mode = 1;
    tick(2);
    rdy_mode = 0;
    f0 = n_fe;
    send(8'h81, 1'b0, NB);
    tick(20);
    rx = 1'b1;
    chk("lit_ferr_pulses", n_fe - f0, 1);
    chk("lit_ferr_empty", rx_valid, 0);
    tick(6);
    send(8'h7E, 1'b1, NB);
    tick(4);
    chk("lit_after_ferr", rx_data, 8'h7E);
    rdy_mode = 1;
    tick(2);
    rdy_mode = 0;
    o0 = n_ov;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, NB);
    tick(4);
    chk("lit_ovr_pulses", n_ov - o0, 1);
    chk("lit_ovr_count", q.size(), 4);
    chk("lit_ovr_head", rx_data, 8'h01);
    rdy_mode = 1;
    tick(6);
    rdy_mode = 0;
    o0 = n_ov;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, NB);
    pop_at = cyc + LAT - 1;
    send(8'h05, 1'b1, NB);
    tick(4);
    chk("lit_popfull_ovr", n_ov - o0, 0);
    chk("lit_popfull_head", rx_data, 8'h02);
    chk("lit_popfull_tail", q[$], 8'h05);
    rdy_mode = 1;
    tick(6);
    rdy_mode = 0;
    send(8'h12, 1'b1, NB);
    send(8'h34, 1'b1, NB);
    tick(2);
    chk("lit_rst_queued", rx_data, 8'h12);
    send(8'hA5, 1'b1, 5);
    rx = 1'b0;
    tick(2);
    btnc = 1'b1;
    rx = 1'b1;
    ev_kind.delete();
    #0.1;
    chk("lit_rst_valid", rx_valid, 0);
    chk("lit_rst_data", rx_data, 8'h00);
    chk("lit_rst_flags", {frame_err, overrun}, 0);
    tick(2);
    btnc = 1'b0;
    tick(4);
    send(8'hC3, 1'b1, NB);
    tick(4);
    chk("lit_after_rst_valid", rx_valid, 1);
    chk("lit_after_rst_data", rx_data, 8'hC3);
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        send(b, 1'b0, NB);
        tick($urandom_range(1, 10));
        rx = 1'b1;
        tick($urandom_range(4, 8));
      end else begin
        send(b, 1'b1, NB);
        tick($urandom_range(0, 5));
      end
    end
    rdy_mode = 1;
    tick(LAT + 10);
    chk("lit_final_empty", rx_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
